// File: rtl/pool_pkg.sv
// pool_pkg: types shared by the pool and its arbiter.
//   pool_ops  : opcode presented to the pool (R1 read, W1 write, FIND lookup)
//   pool_sts  : pool internal sequencer states (MEM0 is the restart state)
//   arb_state : pool_arbiter transaction states
//   idx_width : width of an index into n requesters (at least one bit)
package pool_pkg;

    typedef enum logic [1:0] {
        OpR1   = 2'd0,
        OpW1   = 2'd1,
        OpFind = 2'd2
    } pool_ops;

    typedef enum logic [2:0] {
        StsMem0,
        StsMem1,
        StsScan,
        StsCmp,
        StsDone
    } pool_sts;

    typedef enum logic [2:0] {
        StIdle,
        StAcc,
        StFrun,
        StDone,
        StAbrt
    } arb_state;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req        : per-requester request bits
//   last_grant : index of the most recently served requester
//   pick       : one-hot winner, searching from last_grant+1 upward (mod NREQ)
//   pick_idx   : binary index of the winner
//   any        : at least one request is pending
module rr_pick
    import pool_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   pick_idx,
    output logic            any
);

    logic [IW-1:0] cand;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        cand     = '0;
        // off = NREQ wraps back to last_grant itself, so a lone requester is
        // still served after its own turn.
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = IW'((32'(last_grant) + off) % NREQ);
            if (!any && req[cand]) begin
                any        = 1'b1;
                pick_idx   = cand;
                pick[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool_arbiter.sv
// pool_arbiter: shares one pool port among NREQ requesters
// (0: outer interpreter, 1: inner fetch, 2: TIB loader).
//   clk, rst_n                : clock, asynchronous active-low reset
//   req/req_op/req_ai/req_vi  : per-requester request, opcode, address, write data
//   gnt                       : one-hot grant, held from ACC through DONE
//   done                      : one-cycle completion pulse
//   err/rdata/fhit/fpfa       : results, valid with done and held until the next done
//   busy                      : a transaction is in progress
//   pool_op/pool_ai/pool_vi   : command to the pool
//   pool_rst                  : synchronous reset to the pool (reset tail, FIND abort)
//   pool_vo/pool_bsy/pool_hit/pool_ao0 : pool read data and FIND status/result
module pool_arbiter
    import pool_pkg::*;
#(
    parameter int unsigned DSZ  = 8,
    parameter int unsigned ASZ  = 17,
    parameter int unsigned NREQ = 3,
    parameter int unsigned TMO  = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0][1:0]      req_op,
    input  logic [NREQ-1:0][ASZ-1:0]  req_ai,
    input  logic [NREQ-1:0][DSZ-1:0]  req_vi,
    output logic [NREQ-1:0]           gnt,
    output logic                      done,
    output logic                      err,
    output logic [DSZ-1:0]            rdata,
    output logic                      fhit,
    output logic [ASZ-1:0]            fpfa,
    output logic                      busy,
    output logic [1:0]                pool_op,
    output logic [ASZ-1:0]            pool_ai,
    output logic [DSZ-1:0]            pool_vi,
    output logic                      pool_rst,
    input  logic [DSZ-1:0]            pool_vo,
    input  logic                      pool_bsy,
    input  logic                      pool_hit,
    input  logic [ASZ-1:0]            pool_ao0
);

    localparam int unsigned   IW       = idx_width(NREQ);
    localparam int unsigned   CW       = $clog2(TMO + 1);
    localparam logic [CW-1:0] CntLast  = CW'(TMO - 1);
    localparam logic [IW-1:0] LastInit = IW'(NREQ - 1);

    arb_state        state_q, state_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [IW-1:0]   cur_q, cur_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    pool_ops         op_q, op_d;
    logic [ASZ-1:0]  ai_q, ai_d;
    logic [DSZ-1:0]  vi_q, vi_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            seen_q, seen_d;
    logic            err_q, err_d;
    logic            fhit_q, fhit_d;
    logic [ASZ-1:0]  fpfa_q, fpfa_d;
    logic [DSZ-1:0]  rdata_q, rdata_d;
    logic            prst_q;

    logic [NREQ-1:0] pick;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_d        = cur_q;
        gnt_d        = gnt_q;
        op_d         = op_q;
        ai_d         = ai_q;
        vi_d         = vi_q;
        cnt_d        = cnt_q;
        seen_d       = seen_q;
        err_d        = err_q;
        fhit_d       = fhit_q;
        fpfa_d       = fpfa_q;
        rdata_d      = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d = StAcc;
                    cur_d   = pick_idx;
                    gnt_d   = pick;
                    // The unused opcode encoding is served as a harmless read.
                    op_d    = (req_op[pick_idx] == 2'd3) ? OpR1 : pool_ops'(req_op[pick_idx]);
                    ai_d    = req_ai[pick_idx];
                    vi_d    = req_vi[pick_idx];
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                end
            end
            StAcc: begin
                // Watchdog counts from the ACC cycle, so ABRT lands TMO cycles after ACC.
                cnt_d = cnt_q + 1'b1;
                if (op_q == OpFind) begin
                    state_d = StFrun;
                end else begin
                    state_d = StDone;
                    err_d   = 1'b0;
                end
            end
            StFrun: begin
                if (pool_bsy) begin
                    seen_d = 1'b1;
                end
                // Only a busy->idle edge of the pool ends the search; a low bsy
                // before the pool has picked up the FIND is ignored.
                if (seen_q && !pool_bsy) begin
                    state_d = StDone;
                    err_d   = 1'b0;
                    fhit_d  = pool_hit;
                    fpfa_d  = pool_ao0;
                end else if (cnt_q >= CntLast) begin
                    state_d = StAbrt;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAbrt: begin
                state_d = StDone;
                err_d   = 1'b1;
                fhit_d  = 1'b0;
                fpfa_d  = '0;
            end
            StDone: begin
                state_d      = StIdle;
                last_grant_d = cur_q;
                gnt_d        = '0;
                if (op_q == OpR1) begin
                    rdata_d = pool_vo;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= LastInit;
            cur_q        <= '0;
            gnt_q        <= '0;
            op_q         <= OpR1;
            ai_q         <= '0;
            vi_q         <= '0;
            cnt_q        <= '0;
            seen_q       <= 1'b0;
            err_q        <= 1'b0;
            fhit_q       <= 1'b0;
            fpfa_q       <= '0;
            rdata_q      <= '0;
            prst_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_q        <= cur_d;
            gnt_q        <= gnt_d;
            op_q         <= op_d;
            ai_q         <= ai_d;
            vi_q         <= vi_d;
            cnt_q        <= cnt_d;
            seen_q       <= seen_d;
            err_q        <= err_d;
            fhit_q       <= fhit_d;
            fpfa_q       <= fpfa_d;
            rdata_q      <= rdata_d;
            // Stays high for the first cycle after release so a pool caught
            // mid-FIND restarts from MEM0.
            prst_q       <= 1'b0;
        end
    end

    assign gnt      = gnt_q;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign err      = err_q;
    assign fhit     = fhit_q;
    assign fpfa     = fpfa_q;
    // Read data arrives from the pool during DONE itself; it is registered on
    // the way out so it holds afterwards.
    assign rdata    = (done && op_q == OpR1) ? pool_vo : rdata_q;

    // FIND is presented for the ACC cycle only; otherwise the pool sees a
    // benign read of the latched address.
    assign pool_op  = (state_q == StAcc) ? op_q : OpR1;
    assign pool_ai  = ai_q;
    assign pool_vi  = vi_q;
    assign pool_rst = prst_q | (state_q == StAbrt);

endmodule

// File: tb/tb_pool_arbiter.sv
module tb_pool_arbiter;

    localparam int unsigned DSZ  = 8;
    localparam int unsigned ASZ  = 17;
    localparam int unsigned NREQ = 3;
    localparam int unsigned TMO  = 16;

    localparam logic [ASZ-1:0] KEY = 17'h01234;
    localparam logic [ASZ-1:0] PFA = 17'h00ABC;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [DSZ-1:0]  rdata;
        logic            err;
        logic            fhit;
        logic [ASZ-1:0]  fpfa;
    } res_t;

    logic                      clk;
    logic                      rst_n;
    logic [NREQ-1:0]           req;
    logic [NREQ-1:0][1:0]      req_op;
    logic [NREQ-1:0][ASZ-1:0]  req_ai;
    logic [NREQ-1:0][DSZ-1:0]  req_vi;
    logic [NREQ-1:0]           gnt;
    logic                      done;
    logic                      err;
    logic [DSZ-1:0]            rdata;
    logic                      fhit;
    logic [ASZ-1:0]            fpfa;
    logic                      busy;
    logic [1:0]                pool_op;
    logic [ASZ-1:0]            pool_ai;
    logic [DSZ-1:0]            pool_vi;
    logic                      pool_rst;
    logic [DSZ-1:0]            pool_vo;
    logic                      pool_bsy;
    logic                      pool_hit;
    logic [ASZ-1:0]            pool_ao0;

    int   n_cmp;
    int   n_fail;
    int   cyc;
    logic stuck;

    res_t exp_q[$];
    res_t obs_q[$];
    int   obs_cyc_q[$];

    pool_arbiter #(
        .DSZ  (DSZ),
        .ASZ  (ASZ),
        .NREQ (NREQ),
        .TMO  (TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_op   (req_op),
        .req_ai   (req_ai),
        .req_vi   (req_vi),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .fhit     (fhit),
        .fpfa     (fpfa),
        .busy     (busy),
        .pool_op  (pool_op),
        .pool_ai  (pool_ai),
        .pool_vi  (pool_vi),
        .pool_rst (pool_rst),
        .pool_vo  (pool_vo),
        .pool_bsy (pool_bsy),
        .pool_hit (pool_hit),
        .pool_ao0 (pool_ao0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pool model: synchronous memory plus a FIND engine that looks up KEY.
    logic [DSZ-1:0] mem [0:4095];
    logic [2:0]     fcnt;
    logic [ASZ-1:0] fkey;

    always @(posedge clk) begin
        if (!rst_n) begin
            mem[12'h100] <= 8'h11;
            mem[12'h200] <= 8'h22;
            mem[12'h300] <= 8'h33;
        end else if (pool_op == 2'd1) begin
            mem[pool_ai[11:0]] <= pool_vi;
        end
    end

    always @(posedge clk) pool_vo <= mem[pool_ai[11:0]];

    always @(posedge clk) begin
        if (pool_rst) begin
            pool_bsy <= 1'b0;
            pool_hit <= 1'b0;
            pool_ao0 <= '0;
            fcnt     <= '0;
            fkey     <= '0;
        end else if (pool_op == 2'd2 && !pool_bsy) begin
            pool_bsy <= 1'b1;
            fcnt     <= 3'd4;
            fkey     <= pool_ai;
        end else if (pool_bsy && !stuck) begin
            if (fcnt == 3'd0) begin
                pool_bsy <= 1'b0;
                pool_hit <= (fkey == KEY);
                pool_ao0 <= (fkey == KEY) ? PFA : fkey;
            end else begin
                fcnt <= fcnt - 3'd1;
            end
        end
    end

    // Completion monitor feeding the scoreboard.
    always @(negedge clk) begin
        if (done) begin
            res_t o;
            o.gnt   = gnt;
            o.rdata = rdata;
            o.err   = err;
            o.fhit  = fhit;
            o.fpfa  = fpfa;
            obs_q.push_back(o);
            obs_cyc_q.push_back(cyc);
        end
    end

    task automatic set_req(input int i, input logic [1:0] op, input logic [ASZ-1:0] ai,
                           input logic [DSZ-1:0] vi);
        req_op[i] = op;
        req_ai[i] = ai;
        req_vi[i] = vi;
        req[i]    = 1'b1;
    endtask

    // Waits (bounded) for n completions; each requester drops req once granted.
    task automatic run_until(input int n, input int limit);
        for (int i = 0; i < limit && obs_q.size() < n; i++) begin
            @(negedge clk);
            req = req & ~gnt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rst_gnt: got %b want 000", gnt); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (err !== 1'b0 || fhit !== 1'b0) begin
            n_fail++; $display("FAIL rst_flags: got err=%b fhit=%b want 0/0", err, fhit);
        end
        n_cmp++; if (rdata !== 8'h00 || fpfa !== 17'h0) begin
            n_fail++; $display("FAIL rst_data: got rdata=%h fpfa=%h want 0/0", rdata, fpfa);
        end
        n_cmp++; if (pool_rst !== 1'b1) begin n_fail++; $display("FAIL rst_prst_low: got %b want 1", pool_rst); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (pool_rst !== 1'b1) begin n_fail++; $display("FAIL rst_prst_tail: got %b want 1", pool_rst); end
        @(posedge clk);
        #1;
        n_cmp++; if (pool_rst !== 1'b0) begin n_fail++; $display("FAIL rst_prst_off: got %b want 0", pool_rst); end
    endtask

    task automatic test_back_to_back();
        res_t e, o;
        int   c0, c1;
        obs_cyc_q.delete();
        set_req(0, 2'd0, 17'h00100, 8'h00);
        set_req(1, 2'd0, 17'h00200, 8'h00);
        set_req(2, 2'd0, 17'h00300, 8'h00);
        exp_q.push_back(res_t'{3'b001, 8'h11, 1'b0, 1'b0, 17'h0});
        exp_q.push_back(res_t'{3'b010, 8'h22, 1'b0, 1'b0, 17'h0});
        exp_q.push_back(res_t'{3'b100, 8'h33, 1'b0, 1'b0, 17'h0});
        run_until(3, 60);
        n_cmp++; if (obs_cyc_q.size() != 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d dones want 3", obs_cyc_q.size());
        end else begin
            c0 = obs_cyc_q[1] - obs_cyc_q[0];
            c1 = obs_cyc_q[2] - obs_cyc_q[1];
            n_cmp++; if (c0 != 3 || c1 != 3) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d,%0d want 3,3", c0, c1);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL b2b_result: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_write_read();
        res_t e, o;
        set_req(2, 2'd1, 17'h00050, 8'hA5);
        exp_q.push_back(res_t'{3'b100, 8'h33, 1'b0, 1'b0, 17'h0});
        run_until(1, 30);
        set_req(0, 2'd0, 17'h00050, 8'h00);
        exp_q.push_back(res_t'{3'b001, 8'hA5, 1'b0, 1'b0, 17'h0});
        run_until(2, 30);
        n_cmp++; if (obs_q.size() != 2) begin
            n_fail++; $display("FAIL wr_count: got %0d dones want 2", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL wr_result: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_find_hit();
        res_t e, o;
        int   bad_gnt, nfind;
        bad_gnt = 0; nfind = 0;
        set_req(0, 2'd2, KEY, 8'h00);
        exp_q.push_back(res_t'{3'b001, 8'hA5, 1'b0, 1'b1, PFA});
        for (int i = 0; i < 60 && obs_q.size() < 1; i++) begin
            @(negedge clk);
            req = req & ~gnt;
            if (busy && gnt !== 3'b001) bad_gnt++;
            if (pool_op == 2'd2) nfind++;
        end
        @(posedge clk);
        #1;
        n_cmp++; if (bad_gnt != 0) begin n_fail++; $display("FAIL find_gnt_held: got %0d bad cycles want 0", bad_gnt); end
        n_cmp++; if (nfind != 1) begin n_fail++; $display("FAIL find_op_len: got %0d cycles want 1", nfind); end
        n_cmp++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL find_count: got %0d dones want 1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL find_result: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_watchdog();
        res_t e, o;
        int   acc_c, rst_c, nrst;
        acc_c = -1; rst_c = -1; nrst = 0;
        stuck = 1'b1;
        set_req(1, 2'd2, 17'h00777, 8'h00);
        exp_q.push_back(res_t'{3'b010, 8'hA5, 1'b1, 1'b0, 17'h0});
        for (int i = 0; i < 80 && obs_q.size() < 1; i++) begin
            @(negedge clk);
            req = req & ~gnt;
            if (pool_op == 2'd2 && acc_c < 0) acc_c = cyc;
            if (pool_rst) begin
                nrst++;
                if (rst_c < 0) rst_c = cyc;
            end
        end
        @(posedge clk);
        #1;
        stuck = 1'b0;
        n_cmp++; if (acc_c < 0 || rst_c - acc_c != 16) begin
            n_fail++; $display("FAIL wd_latency: got %0d cycles want 16", rst_c - acc_c);
        end
        n_cmp++; if (nrst != 1) begin n_fail++; $display("FAIL wd_prst_len: got %0d want 1", nrst); end
        n_cmp++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL wd_count: got %0d dones want 1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL wd_result: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_find_miss();
        res_t e, o;
        set_req(1, 2'd2, 17'h00777, 8'h00);
        exp_q.push_back(res_t'{3'b010, 8'hA5, 1'b0, 1'b0, 17'h00777});
        run_until(1, 60);
        n_cmp++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL miss_count: got %0d dones want 1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL miss_result: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_in_frun();
        res_t e, o;
        int   seen_acc;
        seen_acc = 0;
        stuck = 1'b1;
        set_req(2, 2'd2, KEY, 8'h00);
        for (int i = 0; i < 20 && seen_acc == 0; i++) begin
            @(negedge clk);
            if (pool_op == 2'd2) seen_acc = 1;
        end
        n_cmp++; if (seen_acc == 0) begin n_fail++; $display("FAIL rf_acc: got no FIND want FIND"); end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        #1;
        n_cmp++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rf_gnt: got %b want 000", gnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rf_busy: got %b want 0", busy); end
        n_cmp++; if (pool_rst !== 1'b1) begin n_fail++; $display("FAIL rf_prst: got %b want 1", pool_rst); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stuck = 1'b0;
        exp_q.delete(); obs_q.delete();
        @(posedge clk);
        #1;
        set_req(0, 2'd0, 17'h00100, 8'h00);
        set_req(2, 2'd0, 17'h00300, 8'h00);
        exp_q.push_back(res_t'{3'b001, 8'h11, 1'b0, 1'b0, 17'h0});
        exp_q.push_back(res_t'{3'b100, 8'h33, 1'b0, 1'b0, 17'h0});
        run_until(2, 40);
        n_cmp++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL rf_count: got %0d dones want 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL rf_result: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        stuck  = 1'b0;
        rst_n  = 1'b0;
        req    = '0;
        req_op = '0;
        req_ai = '0;
        req_vi = '0;
        test_reset();
        test_back_to_back();
        test_write_read();
        test_find_hit();
        test_watchdog();
        test_find_miss();
        test_reset_in_frun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/pool_arbiter.md
POOL_ARBITER -- requirements
Module: pool_arbiter

Interface
REQ-001 Parameter DSZ, default 8: memory data width.
REQ-002 Parameter ASZ, default 17: memory address width.
REQ-003 Parameter NREQ, default 3: number of requesters (0: outer interpreter, 1: inner fetch, 2: TIB loader).
REQ-004 Parameter TMO, default 4096: FIND watchdog limit in cycles.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request
- req_op  in  NREQ x 2  per-requester opcode (R1, W1, FIND)
- req_ai  in  NREQ x ASZ  per-requester address
- req_vi  in  NREQ x DSZ  per-requester write data
- gnt  out  NREQ  one-hot grant
- done  out  1  one-cycle completion pulse for the granted requester
- err  out  1  FIND aborted by watchdog; valid with done
- rdata  out  DSZ  R1 result; valid with done
- fhit  out  1  FIND hit; valid with done
- fpfa  out  ASZ  FIND result address; valid with done
- busy  out  1  transaction in progress
- pool_op  out  2  opcode to pool
- pool_ai  out  ASZ  address to pool
- pool_vi  out  DSZ  data to pool
- pool_rst  out  1  synchronous active-high reset to pool
- pool_vo  in  DSZ  pool read data
- pool_bsy  in  1  pool FIND busy
- pool_hit  in  1  pool FIND hit
- pool_ao0  in  ASZ  pool FIND result address

Function
REQ-006 States: IDLE, ACC, FRUN, DONE, ABRT.
REQ-007 IDLE: if any req bit is set, grant round-robin starting at last_grant+1 (mod NREQ), latch that requester's op/ai/vi, go to ACC; otherwise stay in IDLE.
REQ-008 ACC (one cycle): drive the latched op/ai/vi to pool; R1 or W1 goes to DONE, FIND goes to FRUN.
REQ-009 Outside ACC, pool_op SHALL be R1 with pool_ai held at the latched address; FIND is never asserted for more than one cycle.
REQ-010 FRUN: set seen flag when pool_bsy=1; when seen=1 and pool_bsy=0, capture pool_hit and pool_ao0 into fhit/fpfa and go to DONE.
REQ-011 FRUN watchdog: a counter cleared on ACC; when it reaches TMO-1 in FRUN, go to ABRT.
REQ-012 ABRT (one cycle): assert pool_rst, set err=1, fhit=0, fpfa=0, go to DONE.
REQ-013 DONE (one cycle): pulse done; for R1, rdata = pool_vo (one-cycle synchronous read latency from ACC); update last_grant; go to IDLE.
REQ-014 gnt is one-hot from ACC through DONE inclusive, and 0 in IDLE; busy = (state != IDLE).
REQ-015 Minimum spacing between grants is one IDLE cycle; back-to-back R1 throughput is 1 per 3 cycles.
REQ-016 A requester dropping req mid-transaction SHALL NOT abort it; the transaction completes and done pulses.
REQ-017 err, rdata, fhit and fpfa hold their values until the next DONE.

Reset
REQ-018 rst_n low asynchronously forces state to IDLE; gnt, done, err, fhit, busy = 0; rdata, fpfa, counter, seen = 0; last_grant = NREQ-1 (requester 0 has first priority).
REQ-019 pool_rst SHALL be asserted while rst_n is low and for one cycle after release, so that a pool mid-FIND restarts in MEM0.

Structure
REQ-020 Package pool_pkg holds the pool_ops enum (R1, W1, FIND), the pool_sts enum, and the arbiter state enum; pool and pool_arbiter both import it.
REQ-021 Sub-module rr_pick: combinational round-robin picker (req, last_grant) -> one-hot plus index.

Verification
REQ-022 req=3'b111, all R1 to 0x100/0x200/0x300 preloaded with 0x11/0x22/0x33 -> grants in order 0, 1, 2; done with rdata 0x11, 0x22, 0x33, each 3 cycles apart.
REQ-023 Requester 2 W1 0xA5 to 0x50, then requester 0 R1 0x50 -> rdata=0xA5.
REQ-024 Requester 0 FIND of an existing word held in TIB -> fhit=1, fpfa equals that word's pfa, err=0, gnt[0] held throughout.
REQ-025 Pool bsy stuck at 1 with TMO=16 -> ABRT 16 cycles after ACC, pool_rst pulses, done with err=1 and fhit=0.
REQ-026 rst_n asserted during FRUN -> gnt=0 and state IDLE immediately; next grant goes to requester 0.
